game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level sequencer for the space-shooter game. It runs in the VGA pixel clock domain, next to the renderer and the bullet/monster datapath.
- Converts raw player buttons and the vertical-sync signal into clean per-frame strobes.
- Owns the game state machine (idle/ready/play/pause/win/lose), fire rate-limiting, lives and level.
- Gates the datapath: monster/bullet/spaceship updates advance only when this block enables them.

Parameters:
- FIRE_COOLDOWN, 8: frames after an accepted shot before the next shot is accepted (1..255).
- START_DELAY, 60: frames spent in READY before entering PLAY (1..255).
- NUM_LIVES, 3: lives loaded at game start (1..3).
- MAX_LEVEL, 15: level saturates at this value.

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock.
- iRST_n  in  1  asynchronous, active-low reset.
- iVS  in  1  raw vertical sync from the sync generator, active low.
- start_btn  in  1  raw button level, asynchronous.
- fire_btn  in  1  raw button level, asynchronous.
- pause_btn  in  1  raw button level, asynchronous.
- remaining_enemies  in  4  live monster count from the datapath.
- player_hit  in  1  one-cycle pulse from the datapath: the ship was hit.
- oFrame_tick  out  1  one-cycle pulse per frame.
- oMove_en  out  1  one-cycle pulse: advance game objects this frame.
- oFire_req  out  1  one-cycle pulse: launch one bullet.
- oClear_field  out  1  one-cycle pulse: reinitialise monsters and bullets.
- oState  out  3  current FSM state encoding.
- oLives  out  2  remaining lives.
- oLevel  out  4  current level.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, cooldown 0, all synchroniser flops 0.
- Synchronisers:
  - start_btn, fire_btn, pause_btn and iVS each pass through 2 flops, then a third "previous" flop for edge detection.
  - A rise edge is sync2 & ~prev. A VS fall edge is ~sync2 & prev.
- Latency:
  - All pulse outputs are registered.
  - A pulse asserts on the 4th rising clock edge after the first edge that samples the new raw level (2 sync + 1 prev + 1 output register).
  - Every pulse is exactly 1 cycle wide.
- oFrame_tick: asserted on each synchronised iVS falling edge, in every state.
- Internal frame counter (8 bit): cleared on every state entry; increments on frame_tick, saturating at 255.
- State encodings: IDLE=0, READY=1, PLAY=2, PAUSED=3, WIN=4, LOSE=5.
- IDLE:
  - start rise -> READY.
  - On this transition: oClear_field pulses, lives = NUM_LIVES, level = 1, cooldown = 0.
- READY: when the frame counter reaches START_DELAY on a frame_tick -> PLAY.
- PLAY:
  - oMove_en = frame_tick.
  - Fire: on a fire rise with cooldown == 0, oFire_req pulses and cooldown loads FIRE_COOLDOWN. A fire rise with cooldown != 0 is dropped, not queued. Holding fire does not repeat.
  - Cooldown decrements on frame_tick and saturates at 0. It decrements in PLAY only; it is frozen in PAUSED.
  - pause rise -> PAUSED.
  - remaining_enemies == 0 -> WIN.
  - player_hit:
    - If lives > 1: lives decrements by 1, oClear_field pulses, next state READY. Level is kept.
    - If lives == 1: lives = 0, next state LOSE.
- Priority within PLAY for simultaneous events: WIN > player_hit > pause > fire.
  - When WIN wins, lives are not decremented and no fire pulse is issued.
  - Any event that causes a state transition suppresses oFire_req in that cycle.
- PAUSED:
  - oMove_en = 0 and oFire_req = 0.
  - player_hit and fire are ignored.
  - pause rise -> PLAY. start rise is ignored.
- WIN: start rise -> READY, level = min(level+1, MAX_LEVEL), oClear_field pulses, lives unchanged.
- LOSE: start rise -> IDLE. The following start rise in IDLE begins a new game.
- Outputs outside PLAY: oMove_en and oFire_req are 0 in every state other than PLAY.
- Button edges and the VS edge in the same cycle are legal. frame_tick-driven updates (cooldown decrement, counter increment) apply in the same cycle as button actions.
- Reset mid-game: outputs return to reset values within the same cycle as iRST_n falling (asynchronous). Any pulse in flight is dropped.
- Unused state encodings 6 and 7 -> IDLE on the next clock.

Test Plan:
- Reset, then start pulse; 60 VS falling edges: oClear_field pulses once, oLives=3, oLevel=1, oState 0->1->2 exactly on the 60th oFrame_tick.
- In PLAY, fire pulsed every 2 frames over 20 frames with FIRE_COOLDOWN=8: exactly 3 oFire_req pulses, spaced ≥8 frames; holding fire high for 20 frames yields exactly 1.
- In PLAY, pause rise, 10 frames, pause rise: oState 2->3->2; oMove_en 0 during pause; cooldown value after resume equals value before pause.
- player_hit three times in PLAY: oLives 3->2->1 with READY re-entry and oClear_field each time; third hit -> oLives=0, oState=5; start -> IDLE.
- remaining_enemies=0 and player_hit in the same cycle: oState=4, oLives unchanged; start -> oLevel 2, oState=1; repeat at level 15 -> stays 15.
- Assert iRST_n low mid-PLAY between clock edges: all outputs 0 and oState=0 immediately, with no oFire_req after release until a new game starts.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// Player/datapath signal bundle for the game flow sequencer.
// master drives raw inputs (renderer side / bench), slave is the sequencer.
interface game_flow_ctrl_if;
    logic       iVS;
    logic       start_btn;
    logic       fire_btn;
    logic       pause_btn;
    logic [3:0] remaining_enemies;
    logic       player_hit;
    logic       oFrame_tick;
    logic       oMove_en;
    logic       oFire_req;
    logic       oClear_field;
    logic [2:0] oState;
    logic [1:0] oLives;
    logic [3:0] oLevel;

    modport master (
        output iVS, start_btn, fire_btn, pause_btn, remaining_enemies, player_hit,
        input  oFrame_tick, oMove_en, oFire_req, oClear_field, oState, oLives, oLevel
    );

    modport slave (
        input  iVS, start_btn, fire_btn, pause_btn, remaining_enemies, player_hit,
        output oFrame_tick, oMove_en, oFire_req, oClear_field, oState, oLives, oLevel
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Space-shooter game sequencer: button/VS synchronisation, game FSM,
// fire rate limiting, lives and level bookkeeping, datapath gating.
module game_flow_ctrl #(
    parameter int unsigned FIRE_COOLDOWN = 8,
    parameter int unsigned START_DELAY   = 60,
    parameter int unsigned NUM_LIVES     = 3,
    parameter int unsigned MAX_LEVEL     = 15
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    game_flow_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_WIN    = 3'd4,
        ST_LOSE   = 3'd5
    } state_t;

    localparam logic [7:0] COOL_L      = 8'(FIRE_COOLDOWN);
    localparam logic [7:0] DELAY_L     = 8'(START_DELAY);
    localparam logic [1:0] LIVES_L     = 2'(NUM_LIVES);
    localparam logic [3:0] LEVEL_MAX_L = 4'(MAX_LEVEL);

    // bit order: {iVS, pause, fire, start}
    logic [3:0] raw_s;
    logic [3:0] sync1_r, sync2_r, prev_r, edge_r;
    logic       start_s, fire_s, pause_s, tick_s;

    state_t     state_r, state_s;
    logic [1:0] lives_r, lives_s;
    logic [3:0] level_r, level_s;
    logic [7:0] cool_r, cool_s, cool_dec_s;
    logic [7:0] cnt_r, cnt_s, cnt_tick_s;
    logic       move_s, fire_req_s, clear_s;
    logic       frame_r, move_r, fire_req_r, clear_r;

    assign raw_s   = {bus.iVS, bus.pause_btn, bus.fire_btn, bus.start_btn};
    assign start_s = edge_r[0];
    assign fire_s  = edge_r[1];
    assign pause_s = edge_r[2];
    assign tick_s  = edge_r[3];

    // Two-flop synchronisers, previous-value flops and registered edge strobes
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_r <= 4'd0;
            sync2_r <= 4'd0;
            prev_r  <= 4'd0;
            edge_r  <= 4'd0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            edge_r  <= {~sync2_r[3] & prev_r[3], sync2_r[2:0] & ~prev_r[2:0]};
        end
    end

    // Game FSM next state, bookkeeping updates and pulse requests
    always_comb begin
        state_s    = state_r;
        lives_s    = lives_r;
        level_s    = level_r;
        move_s     = 1'b0;
        fire_req_s = 1'b0;
        clear_s    = 1'b0;
        cool_dec_s = (tick_s && (cool_r != 8'd0)) ? (cool_r - 8'd1) : cool_r;
        cool_s     = cool_r;
        cnt_tick_s = (tick_s && (cnt_r != 8'hFF)) ? (cnt_r + 8'd1) : cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_READY;
                    clear_s = 1'b1;
                    lives_s = LIVES_L;
                    level_s = 4'd1;
                    cool_s  = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READY: begin
                if (tick_s && (cnt_tick_s >= DELAY_L)) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_PLAY: begin
                move_s = tick_s;
                cool_s = cool_dec_s;
                // Event priority: win, hit, pause, then fire
                if (bus.remaining_enemies == 4'd0) begin
                    state_s = ST_WIN;
                end else if (bus.player_hit) begin
                    if (lives_r > 2'd1) begin
                        lives_s = lives_r - 2'd1;
                        clear_s = 1'b1;
                        state_s = ST_READY;
                    end else begin
                        lives_s = 2'd0;
                        state_s = ST_LOSE;
                    end
                end else if (pause_s) begin
                    state_s = ST_PAUSED;
                end else if (fire_s && (cool_dec_s == 8'd0)) begin
                    fire_req_s = 1'b1;
                    cool_s     = COOL_L;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_PAUSED: begin
                if (pause_s) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_WIN: begin
                if (start_s) begin
                    state_s = ST_READY;
                    clear_s = 1'b1;
                    level_s = (level_r < LEVEL_MAX_L) ? (level_r + 4'd1) : LEVEL_MAX_L;
                end else begin
                    state_s = ST_WIN;
                end
            end
            ST_LOSE: begin
                if (start_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOSE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        cnt_s = (state_s != state_r) ? 8'd0 : cnt_tick_s;
    end

    // State, bookkeeping and registered pulse outputs
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r    <= ST_IDLE;
            lives_r    <= 2'd0;
            level_r    <= 4'd0;
            cool_r     <= 8'd0;
            cnt_r      <= 8'd0;
            frame_r    <= 1'b0;
            move_r     <= 1'b0;
            fire_req_r <= 1'b0;
            clear_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            lives_r    <= lives_s;
            level_r    <= level_s;
            cool_r     <= cool_s;
            cnt_r      <= cnt_s;
            frame_r    <= tick_s;
            move_r     <= move_s;
            fire_req_r <= fire_req_s;
            clear_r    <= clear_s;
        end
    end

    assign bus.oFrame_tick  = frame_r;
    assign bus.oMove_en     = move_r;
    assign bus.oFire_req    = fire_req_r;
    assign bus.oClear_field = clear_r;
    assign bus.oState       = state_r;
    assign bus.oLives       = lives_r;
    assign bus.oLevel       = level_r;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed plus randomized bench for game_flow_ctrl against a rule-level
// game model with a 4-edge input delay line.
module tb_game_flow_ctrl;
    localparam int FIRE_CD  = 8;
    localparam int START_DL = 60;
    localparam int LIVES    = 3;
    localparam int LVL_MAX  = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .FIRE_COOLDOWN(FIRE_CD),
        .START_DELAY  (START_DL),
        .NUM_LIVES    (LIVES),
        .MAX_LEVEL    (LVL_MAX)
    ) dut (
        .iVGA_CLK(clk),
        .iRST_n  (rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model: game rules plus raw-sample history per button
    int m_state, m_lives, m_level, m_cool, m_cnt;
    bit e_tick, e_move, e_fire, e_clear;
    bit [3:0] h_start, h_fire, h_pause, h_vs;

    // observation counters taken from DUT outputs
    int tick_obs, fire_obs, clear_obs, move_obs;
    int last_fire_tick, min_gap, play_tick, prev_state_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_level = 0; m_cool = 0; m_cnt = 0;
        e_tick = 0; e_move = 0; e_fire = 0; e_clear = 0;
        h_start = 4'd0; h_fire = 4'd0; h_pause = 4'd0; h_vs = 4'd0;
    endtask

    task automatic model_step();
        bit st_e, fi_e, pa_e, tk_e;
        int prev_st, cool_eff;
        // an event acts on the edge three samples after its raw level was first seen
        st_e = h_start[2] & ~h_start[3];
        fi_e = h_fire[2]  & ~h_fire[3];
        pa_e = h_pause[2] & ~h_pause[3];
        tk_e = ~h_vs[2]   &  h_vs[3];
        h_start = {h_start[2:0], bus.start_btn};
        h_fire  = {h_fire[2:0],  bus.fire_btn};
        h_pause = {h_pause[2:0], bus.pause_btn};
        h_vs    = {h_vs[2:0],    bus.iVS};
        prev_st = m_state;
        e_tick = tk_e; e_move = 0; e_fire = 0; e_clear = 0;
        case (m_state)
            0: if (st_e) begin
                   m_state = 1; m_lives = LIVES; m_level = 1; m_cool = 0; e_clear = 1;
               end
            1: if (tk_e && (m_cnt + 1 >= START_DL)) m_state = 2;
            2: begin
                   e_move = tk_e;
                   cool_eff = (tk_e && m_cool > 0) ? m_cool - 1 : m_cool;
                   m_cool = cool_eff;
                   if (bus.remaining_enemies == 4'd0) m_state = 4;
                   else if (bus.player_hit) begin
                       if (m_lives > 1) begin m_lives--; e_clear = 1; m_state = 1; end
                       else begin m_lives = 0; m_state = 5; end
                   end
                   else if (pa_e) m_state = 3;
                   else if (fi_e && cool_eff == 0) begin e_fire = 1; m_cool = FIRE_CD; end
               end
            3: if (pa_e) m_state = 2;
            4: if (st_e) begin
                   m_state = 1; e_clear = 1;
                   m_level = (m_level < LVL_MAX) ? m_level + 1 : LVL_MAX;
               end
            5: if (st_e) m_state = 0;
            default: m_state = 0;
        endcase
        if (m_state != prev_st) m_cnt = 0;
        else if (tk_e && m_cnt < 255) m_cnt++;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        chk("frame_tick", 32'(bus.oFrame_tick),  32'(e_tick));
        chk("move_en",    32'(bus.oMove_en),     32'(e_move));
        chk("fire_req",   32'(bus.oFire_req),    32'(e_fire));
        chk("clear",      32'(bus.oClear_field), 32'(e_clear));
        chk("state",      32'(bus.oState),       32'(m_state));
        chk("lives",      32'(bus.oLives),       32'(m_lives));
        chk("level",      32'(bus.oLevel),       32'(m_level));
        if (bus.oFrame_tick === 1'b1) tick_obs++;
        if (bus.oMove_en === 1'b1) move_obs++;
        if (bus.oClear_field === 1'b1) clear_obs++;
        if (bus.oFire_req === 1'b1) begin
            if (last_fire_tick >= 0 && (tick_obs - last_fire_tick) < min_gap)
                min_gap = tick_obs - last_fire_tick;
            last_fire_tick = tick_obs;
            fire_obs++;
        end
        if (prev_state_obs == 1 && bus.oState == 3'd2) play_tick = tick_obs;
        prev_state_obs = int'(bus.oState);
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            bus.iVS = 1'b0;
            cycle(); cycle();
            bus.iVS = 1'b1;
            for (int c = 0; c < 6; c++) cycle();
        end
    endtask

    // 0 start, 1 fire, 2 pause
    task automatic press(input int which);
        if (which == 0) bus.start_btn = 1'b1;
        else if (which == 1) bus.fire_btn = 1'b1;
        else bus.pause_btn = 1'b1;
        cycle(); cycle();
        bus.start_btn = 1'b0; bus.fire_btn = 1'b0; bus.pause_btn = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
    endtask

    task automatic clear_counters();
        tick_obs = 0; fire_obs = 0; clear_obs = 0; move_obs = 0;
        last_fire_tick = -1; min_gap = 1000; play_tick = -1;
    endtask

    initial begin
        bus.iVS = 1'b1; bus.start_btn = 1'b0; bus.fire_btn = 1'b0; bus.pause_btn = 1'b0;
        bus.remaining_enemies = 4'd5; bus.player_hit = 1'b0;
        prev_state_obs = 0;
        model_reset();
        clear_counters();

        // reset state
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (4) cycle();

        // game start and READY delay
        clear_counters();
        press(0);
        run_frames(START_DL + 1);
        chk("start_clear_count", 32'(clear_obs), 32'd1);
        chk("play_on_tick_60",   32'(play_tick), 32'(START_DL));
        chk("start_lives",       32'(bus.oLives), 32'(LIVES));

        // fire every 2 frames over 20 frames
        clear_counters();
        for (int i = 0; i < 10; i++) begin
            bus.fire_btn = 1'b1; run_frames(1);
            bus.fire_btn = 1'b0; run_frames(1);
        end
        chk("fire_every2_count", 32'(fire_obs), 32'd3);
        chk("fire_gap_ge_cd",    32'(min_gap >= FIRE_CD), 32'd1);

        // held fire fires once
        run_frames(10);
        clear_counters();
        bus.fire_btn = 1'b1; run_frames(20); bus.fire_btn = 1'b0;
        chk("fire_hold_count", 32'(fire_obs), 32'd1);

        // pause / resume, with a shot just before pausing
        run_frames(10);
        bus.fire_btn = 1'b1; run_frames(1); bus.fire_btn = 1'b0;
        press(2);
        chk("paused_state", 32'(bus.oState), 32'd3);
        clear_counters();
        bus.fire_btn = 1'b1; run_frames(10); bus.fire_btn = 1'b0;
        chk("paused_move_count", 32'(move_obs), 32'd0);
        chk("paused_fire_count", 32'(fire_obs), 32'd0);
        press(2);
        chk("resumed_state", 32'(bus.oState), 32'd2);
        for (int i = 0; i < 8; i++) begin
            bus.fire_btn = 1'b1; run_frames(1); bus.fire_btn = 1'b0;
        end

        // three hits
        clear_counters();
        for (int i = 0; i < 3; i++) begin
            bus.player_hit = 1'b1; cycle(); bus.player_hit = 1'b0;
            chk("hit_lives", 32'(bus.oLives), 32'(LIVES - 1 - i));
            chk("hit_state", 32'(bus.oState), (i < 2) ? 32'd1 : 32'd5);
            if (i < 2) run_frames(START_DL + 1);
        end
        chk("hit_clear_count", 32'(clear_obs), 32'd2);
        press(0);
        chk("lose_to_idle", 32'(bus.oState), 32'd0);

        // win beats simultaneous hit, then level saturation
        press(0);
        run_frames(START_DL + 1);
        for (int k = 0; k < LVL_MAX; k++) begin
            bus.remaining_enemies = 4'd0; bus.player_hit = (k == 0);
            cycle();
            bus.remaining_enemies = 4'd5; bus.player_hit = 1'b0;
            chk("win_state", 32'(bus.oState), 32'd4);
            chk("win_lives", 32'(bus.oLives), 32'(LIVES));
            press(0);
            chk("win_level", 32'(bus.oLevel), 32'((k + 2 > LVL_MAX) ? LVL_MAX : k + 2));
            chk("win_ready", 32'(bus.oState), 32'd1);
            run_frames(START_DL + 1);
        end

        // asynchronous reset mid-PLAY with a shot in flight
        bus.fire_btn = 1'b1; cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_frame", 32'(bus.oFrame_tick), 32'd0);
        chk("rst_fire",  32'(bus.oFire_req),   32'd0);
        chk("rst_move",  32'(bus.oMove_en),    32'd0);
        chk("rst_clear", 32'(bus.oClear_field), 32'd0);
        chk("rst_state", 32'(bus.oState),      32'd0);
        chk("rst_lives", 32'(bus.oLives),      32'd0);
        chk("rst_level", 32'(bus.oLevel),      32'd0);
        model_reset();
        bus.fire_btn = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        clear_counters();
        for (int i = 0; i < 4; i++) begin
            bus.fire_btn = 1'b1; run_frames(1); bus.fire_btn = 1'b0; run_frames(1);
        end
        chk("no_fire_after_reset", 32'(fire_obs), 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 5000; c++) begin
            bus.iVS = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 15) == 0) bus.start_btn = ~bus.start_btn;
            if ($urandom_range(0, 7) == 0)  bus.fire_btn  = ~bus.fire_btn;
            if ($urandom_range(0, 40) == 0) bus.pause_btn = ~bus.pause_btn;
            bus.player_hit = ($urandom_range(0, 60) == 0);
            bus.remaining_enemies = ($urandom_range(0, 80) == 0) ? 4'd0 : 4'(1 + $urandom_range(0, 14));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
